// File: rtl/cache_ctrl_nway_if.sv
// ----------------------------------------------------------------------------
// cache_ctrl_nway_if
//
// Bundles the CPU-side request port, the physical-memory port and the
// data-array steering outputs of cache_ctrl_nway.
//
// Handshake (one rule for both sides):
//   CPU side    : mem_read / mem_write are held, together with mem_address and
//                 mem_byte_enable, until the single-cycle mem_resp pulse; the
//                 request completes in the cycle mem_resp is high.
//   Memory side : pmem_read / pmem_write are held, with a stable pmem_address,
//                 until memory answers with a single-cycle pmem_resp; the
//                 transfer completes in the cycle pmem_resp is high.
//
// Modports:
//   slave  - the controller (drives mem_resp, pmem_*, data_*, hit, state)
//   master - the environment: CPU plus memory (drives mem_*, pmem_resp)
//
// Signals:
//   mem_address, mem_read, mem_write, mem_byte_enable, mem_resp   CPU port
//   pmem_read, pmem_write, pmem_address, pmem_resp                memory port
//   data_way, data_write_en, data_src_mem                         data array
//   hit                                                            tag match
//   state                                                          FSM state
// ----------------------------------------------------------------------------
interface cache_ctrl_nway_if #(
    parameter int S_OFFSET = 5,
    parameter int WAYS     = 4
);
    localparam int W      = $clog2(WAYS);
    localparam int S_LINE = 2 ** S_OFFSET;

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [S_LINE-1:0] mem_byte_enable;
    logic              mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic              pmem_resp;

    logic [W-1:0]      data_way;
    logic [S_LINE-1:0] data_write_en;
    logic              data_src_mem;

    logic              hit;
    logic [1:0]        state;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_address,
        output data_way, data_write_en, data_src_mem, hit, state
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_address,
        input  data_way, data_write_en, data_src_mem, hit, state
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// ----------------------------------------------------------------------------
// cache_ctrl_nway
//
// N-way set-associative, write-back, write-allocate cache controller. Holds
// per-set tags, valid bits, dirty bits and tree pseudo-LRU state, and steers
// an external data array through way select and byte write enables.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset; clears valid/dirty/PLRU, FSM to IDLE
//   bus  - cache_ctrl_nway_if.slave: CPU request port, physical memory port,
//          data-array steering (data_way, data_write_en, data_src_mem), the
//          combinational hit flag and the FSM state (IDLE=0, LOOKUP=1,
//          WRITEBACK=2, FILL=3).
//
// Victim choice on a miss: lowest-index invalid way, otherwise the tree-PLRU
// victim. Only a dirty valid victim is written back before the fill.
// ----------------------------------------------------------------------------
module cache_ctrl_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int WAYS     = 4,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input logic               clk,
    input logic               rst,
    cache_ctrl_nway_if.slave  bus
);
    localparam int W      = $clog2(WAYS);
    localparam int SETS   = 2 ** S_INDEX;
    localparam int S_LINE = 2 ** S_OFFSET;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [W-1:0] victim_q, victim_d;

    // Metadata. PLRU tree nodes are numbered 1..WAYS-1 (root = 1, children of
    // node n are 2n and 2n+1); a node bit of 0 points the victim to the lower
    // child, 1 to the upper child.
    logic [S_TAG-1:0] tag_mem [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-1:1]  plru_q  [SETS];

    // Address fields
    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tag_in;
    logic               unused_offset;

    assign idx           = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign tag_in        = bus.mem_address[31 -: S_TAG];
    assign unused_offset = ^bus.mem_address[S_OFFSET-1:0];

    // Indexed-set views
    logic [WAYS-1:0] valid_cur;
    logic [WAYS-1:0] dirty_cur;
    logic [WAYS-1:1] plru_cur;

    assign valid_cur = valid_q[idx];
    assign dirty_cur = dirty_q[idx];
    assign plru_cur  = plru_q[idx];

    // ------------------------------------------------------------------
    // Tag compare and invalid-way search (lowest index wins)
    // ------------------------------------------------------------------
    logic         hit_any;
    logic [W-1:0] hit_way;
    logic         inv_any;
    logic [W-1:0] inv_way;

    always_comb begin : tag_match
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_cur[i] && (tag_mem[idx][i] == tag_in)) begin
                hit_any = 1'b1;
                hit_way = W'(i);
            end
            if (!valid_cur[i]) begin
                inv_any = 1'b1;
                inv_way = W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // PLRU victim: walk from the root following the node bits. The inner
    // loop selects the current node's bit without a variable-width index.
    // ------------------------------------------------------------------
    logic [W-1:0] plru_way;

    always_comb begin : plru_victim
        int   node;
        logic b;
        node = 1;
        b    = 1'b0;
        for (int l = 0; l < W; l++) begin
            b = 1'b0;
            for (int n = 1; n < WAYS; n++) begin
                if (node == n) b = plru_cur[n];
            end
            node = 2 * node + int'(b);
        end
        plru_way = W'(node - WAYS);
    end

    // ------------------------------------------------------------------
    // PLRU update on a hit: every node on the hit way's path is set to
    // point away from it. The way number's bits, MSB first, are the
    // directions taken from the root.
    // ------------------------------------------------------------------
    logic [WAYS-1:1] plru_upd;

    always_comb begin : plru_update
        int   node;
        logic dir;
        plru_upd = plru_cur;
        node     = 1;
        dir      = 1'b0;
        for (int l = 0; l < W; l++) begin
            dir = hit_way[W-1-l];
            for (int n = 1; n < WAYS; n++) begin
                if (node == n) plru_upd[n] = ~dir;
            end
            node = 2 * node + int'(dir);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    logic lookup_hit;
    logic fill_done;
    logic is_write;

    // A simultaneous read and write request is handled as a write.
    assign is_write = bus.mem_write;

    always_comb begin : fsm_comb
        state_d           = state_q;
        victim_d          = victim_q;
        lookup_hit        = 1'b0;
        fill_done         = 1'b0;
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_address  = '0;
        bus.data_way      = '0;
        bus.data_write_en = '0;
        bus.data_src_mem  = 1'b0;
        bus.hit           = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) state_d = LOOKUP;
            end

            LOOKUP: begin
                bus.hit = hit_any;
                if (hit_any) begin
                    lookup_hit   = 1'b1;
                    bus.mem_resp = 1'b1;
                    bus.data_way = hit_way;
                    if (is_write) bus.data_write_en = bus.mem_byte_enable;
                    state_d = IDLE;
                end else begin
                    victim_d = inv_any ? inv_way : plru_way;
                    if (valid_cur[victim_d] && dirty_cur[victim_d]) state_d = WRITEBACK;
                    else                                             state_d = FILL;
                end
            end

            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_mem[idx][victim_q], idx, {S_OFFSET{1'b0}}};
                bus.data_way     = victim_q;
                if (bus.pmem_resp) state_d = FILL;
            end

            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {tag_in, idx, {S_OFFSET{1'b0}}};
                bus.data_way     = victim_q;
                bus.data_src_mem = 1'b1;
                if (bus.pmem_resp) begin
                    fill_done         = 1'b1;
                    bus.data_write_en = {S_LINE{1'b1}};
                    // Return to LOOKUP so the request completes as an ordinary hit.
                    state_d = LOOKUP;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.state = state_q;

    // ------------------------------------------------------------------
    // Metadata: valid, dirty, PLRU (reset) -- only the indexed set changes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (lookup_hit) begin
                plru_q[idx] <= plru_upd;
                if (is_write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tags carry no reset: a tag is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_done) tag_mem[idx][victim_q] <= tag_in;
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
module tb_cache_ctrl_nway;
    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int WAYS     = 4;
    localparam int MEM_LAT  = 3;
    localparam int EW       = 39;

    localparam logic [1:0] K_RESP = 2'd0;
    localparam logic [1:0] K_PRD  = 2'd1;
    localparam logic [1:0] K_PWR  = 2'd2;
    localparam logic [1:0] K_DWR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.S_OFFSET(S_OFFSET), .WAYS(WAYS)) bus ();

    cache_ctrl_nway #(
        .S_OFFSET(S_OFFSET),
        .S_INDEX (S_INDEX),
        .WAYS    (WAYS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [EW-1:0] exp_q[$];

    // Event word: {kind, data_src_mem, way, address-or-byte-enables}
    function automatic logic [EW-1:0] ev(logic [1:0] k, logic s, logic [3:0] w, logic [31:0] d);
        return {k, s, w, d};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic sb_check(string name, logic [EW-1:0] got);
        logic [EW-1:0] want;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got event %h want no event", name, got);
        end else begin
            want = exp_q.pop_front();
            check(name, 64'(got), 64'(want));
        end
    endtask

    // ---------------- expected-event helpers ----------------
    task automatic exp_fill(logic [31:0] a, int way);
        exp_q.push_back(ev(K_PRD, 1'b1, 4'(way), a));
        exp_q.push_back(ev(K_DWR, 1'b1, 4'(way), 32'hFFFF_FFFF));
    endtask

    task automatic exp_wb(logic [31:0] a, int way);
        exp_q.push_back(ev(K_PWR, 1'b0, 4'(way), a));
    endtask

    task automatic exp_wr(int way, logic [31:0] be);
        exp_q.push_back(ev(K_DWR, 1'b0, 4'(way), be));
    endtask

    task automatic exp_resp(logic [31:0] a, int way);
        exp_q.push_back(ev(K_RESP, 1'b0, 4'(way), a));
    endtask

    // ---------------- memory model ----------------
    // Answers each held strobe with a one-cycle pmem_resp after MEM_LAT cycles.
    initial begin
        int cnt;
        logic was_resp;
        cnt = 0;
        bus.pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            was_resp = bus.pmem_resp;
            bus.pmem_resp = 1'b0;
            if (was_resp) cnt = 0;
            if (!rst && (bus.pmem_read || bus.pmem_write)) begin
                cnt++;
                if (cnt == MEM_LAT) begin
                    bus.pmem_resp = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prd, pwr, prs, prst;
        logic [31:0] pa;
        prd = 1'b0; pwr = 1'b0; prs = 1'b0; prst = 1'b1; pa = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.pmem_read) check("pmem_excl", 64'(bus.pmem_write), 64'd0);
                if (!prst && (prd || pwr) && !prs)
                    check("pmem_hold", {bus.pmem_read, bus.pmem_write, bus.pmem_address},
                          {prd, pwr, pa});
                if (bus.pmem_write && bus.pmem_resp)
                    sb_check("writeback", ev(K_PWR, bus.data_src_mem, 4'(bus.data_way), bus.pmem_address));
                if (bus.pmem_read && bus.pmem_resp)
                    sb_check("fill", ev(K_PRD, bus.data_src_mem, 4'(bus.data_way), bus.pmem_address));
                if (bus.data_write_en != '0)
                    sb_check("data_write", ev(K_DWR, bus.data_src_mem, 4'(bus.data_way), bus.data_write_en));
                if (bus.mem_resp)
                    sb_check("mem_resp", ev(K_RESP, bus.data_src_mem, 4'(bus.data_way), bus.mem_address));
            end
            prd  = bus.pmem_read;
            pwr  = bus.pmem_write;
            prs  = bus.pmem_resp;
            pa   = bus.pmem_address;
            prst = rst;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Latency counts the request cycle through the mem_resp cycle inclusive.
    task automatic run_req(string name, logic [31:0] a, bit rd, bit wr, logic [31:0] be, int exp_lat);
        int n;
        bit done;
        bus.mem_address     = a;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.mem_resp) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: got no mem_resp in 200 cycles want latency %0d", name, exp_lat);
        end else begin
            check({name, "_latency"}, 64'(n), 64'(exp_lat));
        end
        @(posedge clk); #2;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;

        do_reset();
        mon_en = 1'b1;

        // Reset state
        check("rst_strobes", {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.data_src_mem, bus.hit}, 64'd0);
        check("rst_pmem_address", 64'(bus.pmem_address), 64'd0);
        check("rst_data_write_en", 64'(bus.data_write_en), 64'd0);
        check("rst_data_way", 64'(bus.data_way), 64'd0);
        check("rst_state", 64'(bus.state), 64'd0);

        // Cold read miss, then the same read hits
        exp_fill(32'h0000_1040, 0); exp_resp(32'h0000_1040, 0);
        run_req("cold_miss", 32'h0000_1040, 1, 0, 32'h0, 6);
        exp_resp(32'h0000_1040, 0);
        run_req("cold_rehit", 32'h0000_1040, 1, 0, 32'h0, 2);

        // Invalid-way priority
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_fill(32'h040 + 32'(i) * 32'h100, i);
            exp_resp(32'h040 + 32'(i) * 32'h100, i);
            run_req("inv_prio", 32'h040 + 32'(i) * 32'h100, 1, 0, 32'h0, 6);
        end

        // Dirty eviction, then PLRU walk proving the line came back clean
        do_reset();
        exp_fill(32'h040, 0); exp_wr(0, 32'h0000_000F); exp_resp(32'h040, 0);
        run_req("dirty_wr", 32'h040, 0, 1, 32'h0000_000F, 6);
        for (int i = 1; i < 4; i++) begin
            exp_fill(32'h040 + 32'(i) * 32'h100, i);
            exp_resp(32'h040 + 32'(i) * 32'h100, i);
            run_req("dirty_fillup", 32'h040 + 32'(i) * 32'h100, 1, 0, 32'h0, 6);
        end
        exp_wb(32'h040, 0); exp_fill(32'h440, 0); exp_resp(32'h440, 0);
        run_req("dirty_evict", 32'h440, 1, 0, 32'h0, 9);
        exp_fill(32'h540, 2); exp_resp(32'h540, 2);
        run_req("plru_walk_540", 32'h540, 1, 0, 32'h0, 6);
        exp_fill(32'h640, 1); exp_resp(32'h640, 1);
        run_req("plru_walk_640", 32'h640, 1, 0, 32'h0, 6);
        exp_fill(32'h740, 3); exp_resp(32'h740, 3);
        run_req("plru_walk_740", 32'h740, 1, 0, 32'h0, 6);
        exp_fill(32'h840, 0); exp_resp(32'h840, 0);
        run_req("clean_after_wb", 32'h840, 1, 0, 32'h0, 6);

        // Clean eviction by PLRU
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_fill(32'h040 + 32'(i) * 32'h100, i);
            exp_resp(32'h040 + 32'(i) * 32'h100, i);
            run_req("plru_fill", 32'h040 + 32'(i) * 32'h100, 1, 0, 32'h0, 6);
        end
        exp_resp(32'h040, 0);
        run_req("plru_touch", 32'h040, 1, 0, 32'h0, 2);
        exp_fill(32'h540, 2); exp_resp(32'h540, 2);
        run_req("plru_victim", 32'h540, 1, 0, 32'h0, 6);

        // Set isolation with all ways of set 2 dirty
        do_reset();
        exp_fill(32'h040, 0); exp_wr(0, 32'h0000_0003); exp_resp(32'h040, 0);
        run_req("iso_w0", 32'h040, 0, 1, 32'h0000_0003, 6);
        exp_fill(32'h140, 1); exp_wr(1, 32'h0000_00F0); exp_resp(32'h140, 1);
        run_req("iso_w1", 32'h140, 0, 1, 32'h0000_00F0, 6);
        exp_fill(32'h240, 2); exp_wr(2, 32'h0000_FF00); exp_resp(32'h240, 2);
        run_req("iso_w2", 32'h240, 0, 1, 32'h0000_FF00, 6);
        exp_fill(32'h340, 3); exp_wr(3, 32'h8000_0000); exp_resp(32'h340, 3);
        run_req("iso_w3", 32'h340, 0, 1, 32'h8000_0000, 6);
        exp_fill(32'h060, 0); exp_resp(32'h060, 0);
        run_req("iso_set3", 32'h060, 1, 0, 32'h0, 6);
        // Read and write together act as a write hit
        exp_wr(1, 32'h0000_0001); exp_resp(32'h140, 1);
        run_req("rdwr_hit", 32'h140, 1, 1, 32'h0000_0001, 2);
        exp_wb(32'h240, 2); exp_fill(32'h440, 2); exp_resp(32'h440, 2);
        run_req("iso_dirty_evict", 32'h440, 1, 0, 32'h0, 9);

        // Reset in the middle of a fill
        do_reset();
        bus.mem_address = 32'h0000_1040;
        bus.mem_read    = 1'b1;
        n = 0;
        while (!bus.pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midfill_pmem_read_seen", 64'(bus.pmem_read), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("midfill_pmem_read_drop", 64'(bus.pmem_read), 64'd0);
        check("midfill_state", 64'(bus.state), 64'd0);
        @(posedge clk); #2;
        exp_fill(32'h0000_1040, 0); exp_resp(32'h0000_1040, 0);
        run_req("midfill_reread", 32'h0000_1040, 1, 0, 32'h0, 6);

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised N-way set-associative, write-back, write-allocate cache controller. It sits between the CPU memory port and physical memory. It owns the per-set metadata internally: tags, valid bits, dirty bits and tree pseudo-LRU state. It steers an external data array by way select and byte write enables. It generalises the two-way controller to any power-of-two way count, prefers invalid ways as victims, and writes back only a dirty victim.

## Interface
- S_OFFSET, 5, log2 bytes per line (line = 2**S_OFFSET bytes)
- S_INDEX, 3, log2 number of sets
- WAYS, 4, associativity; power of two, 2..16
- S_TAG, 32-S_OFFSET-S_INDEX, tag width (derived)
- W = $clog2(WAYS) (derived localparam)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_address  in  32  CPU byte address; index = [S_OFFSET+S_INDEX-1:S_OFFSET]
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2**S_OFFSET  byte mask for writes
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  32  line-aligned physical address (low S_OFFSET bits zero)
- pmem_resp  in  1  memory completion, one cycle
- data_way  out  W  way addressed in the data array this cycle
- data_write_en  out  2**S_OFFSET  byte write enables into data_way
- data_src_mem  out  1  1: data array write data from pmem line; 0: from CPU
- hit  out  1  combinational tag match in LOOKUP (debug)

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FILL.
- IDLE: mem_read or mem_write → LOOKUP. If both are asserted, treat the request as a write.
- LOOKUP: compare the tag against all valid ways of the indexed set.
  - Hit on way h: mem_resp=1, data_way=h, PLRU updated toward h, next IDLE.
  - Write hit additionally: data_write_en=mem_byte_enable, data_src_mem=0, dirty[h]=1.
  - Miss: choose victim v and latch it. v is the lowest-index invalid way if any, else the PLRU victim.
  - If valid[v] and dirty[v] → WRITEBACK, else → FILL.
- WRITEBACK: pmem_write=1, pmem_address={tag[v], index, 0}, data_way=v. On pmem_resp → FILL.
- FILL: pmem_read=1, pmem_address={mem tag, index, 0}, data_way=v, data_src_mem=1.
  - On the pmem_resp cycle: data_write_en = all ones, tag[v] = mem tag, valid[v]=1, dirty[v]=0, then → LOOKUP.
  - The following LOOKUP hits and completes the request as a normal hit.
- Tree PLRU: WAYS-1 bits per set, node 1 is root, children 2n and 2n+1.
  - Bit 0 = victim in lower half; bit 1 = victim in upper half.
  - Access to way w sets every node on w's path to point away from w.
  - Victim is found by following the bits from the root.
- Only LOOKUP hits update PLRU. FILL does not.
- Metadata in sets other than the indexed set is never modified.

## Timing
- Reset:
  - All outputs are 0 (combinational outputs are 0 because state = IDLE).
  - All valid, dirty and PLRU bits are cleared.
  - Tags are not reset.
- Read/write hit: request sampled in IDLE at edge 0; mem_resp high in the cycle after edge 0 (2-cycle latency).
- Clean miss: IDLE, LOOKUP, then FILL held until pmem_resp, then LOOKUP with mem_resp. Latency = fill latency + 3 cycles.
- Dirty miss: same as clean miss plus the WRITEBACK duration.
- pmem_read and pmem_write are never high together. Each is held constant with a stable address until pmem_resp.
- data_write_en is nonzero only in a LOOKUP write hit or the FILL pmem_resp cycle.
- CPU must hold address, request and byte enables stable until mem_resp. Behaviour is undefined otherwise.
- Reset mid-operation (any state): next cycle state = IDLE, pmem strobes drop, all lines become invalid. The abandoned memory transaction must be tolerated by memory.
- A pmem_resp arriving in IDLE or LOOKUP is ignored.

## Test plan
- Cold read miss, defaults:
  - Stimulus: after reset, read 0x0000_1040.
  - Required: LOOKUP misses; pmem_read=1 with pmem_address=0x0000_1040, data_way=0; fill with 3-cycle pmem latency; then LOOKUP hit and mem_resp exactly once.
  - Repeat the read → mem_resp 2 cycles after the request, no pmem activity.
- Invalid-way priority:
  - Stimulus: read 0x040, 0x140, 0x240, 0x340 (all index 2).
  - Required: fills land in ways 0, 1, 2, 3 in order; no pmem_write.
- Dirty eviction:
  - Stimulus: write 0x040 with byte enable 0x0000_000F, then read 0x140, 0x240, 0x340, then read 0x440.
  - Required for the write: data_write_en=0x0000_000F on way 0.
  - Required for 0x440: pmem_write with pmem_address=0x0000_0040 on way 0, then pmem_read 0x0000_0440 into way 0, with dirty[0]=0 afterwards.
- Clean eviction by PLRU:
  - Stimulus: read 0x040, 0x140, 0x240, 0x340, 0x040, then read 0x540.
  - Required: no pmem_write; victim is way 2 (PLRU bits root=1, node2=1, node3=0).
- Reset mid-FILL:
  - Stimulus: assert rst for 1 cycle while pmem_read is high.
  - Required: pmem_read=0 the next cycle; a later read of the same address misses.
- Set isolation:
  - Stimulus: fill all four ways of index 2 with dirty lines, then read 0x060 (index 3).
  - Required: fill into way 0 of set 3 with no writeback.
